// File: rtl/move_sequencer_pkg.sv
// Shared encodings for the move sequencer and the square array it drives.
//   SM_*  : array state_mode commands (find victim, find aggressor, write)
//   MM_*  : array mask_mode commands
//   OP_*  : host command opcodes
//   EMPTY : piece code written by OP_CLEAR
//   seq_state_e : sequencer FSM states
package move_sequencer_pkg;

    localparam logic [2:0] SM_FV = 3'd0;   // array reports victim priorities
    localparam logic [2:0] SM_FA = 3'd1;   // array reports aggressors of the ss1 square
    localparam logic [2:0] SM_W  = 3'd2;   // array writes write_bus into the ss1 square

    localparam logic [1:0] MM_NONE    = 2'd0;
    localparam logic [1:0] MM_EAV_EAA = 2'd1;  // enable all victims and all aggressors
    localparam logic [1:0] MM_DV_EAA  = 2'd2;  // disable victim ss1, re-enable all aggressors
    localparam logic [1:0] MM_DA      = 2'd3;  // disable aggressor ss1

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_GEN   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_ABORT = 2'd3;

    localparam logic [3:0] EMPTY = 4'd0;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StClear,
        StInit,
        StFvIssue,
        StFvCap,
        StDv,
        StFaIssue,
        StFaCap,
        StEmit,
        StDa,
        StDone
    } seq_state_e;

endpackage

// File: rtl/move_sequencer_prio.sv
// prio_argmax: reduces NSQ per-square priorities to the maximum value and the
// lowest square index holding it, through a balanced comparator tree followed
// by one register stage.
//   clk, rst_n : clock, asynchronous active-low reset (outputs reset to 0)
//   prio       : {sqN-1..sq0} priorities, PW bits each
//   max_prio   : registered maximum priority
//   max_idx    : registered index of the winning square
// NSQ must be a power of two so the heap-ordered tree keeps lower squares on
// the left; ties then resolve to the left child, i.e. the lowest index.
module prio_argmax #(
    parameter int unsigned NSQ = 64,
    parameter int unsigned PW  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSQ*PW-1:0]       prio,
    output logic [PW-1:0]           max_prio,
    output logic [$clog2(NSQ)-1:0]  max_idx
);
    localparam int unsigned IW    = $clog2(NSQ);
    localparam int unsigned NNODE = 2 * NSQ - 1;

    logic [PW-1:0] tree_max;
    logic [IW-1:0] tree_idx;

    always_comb begin : tree
        logic [PW-1:0] val [NNODE];
        logic [IW-1:0] idx [NNODE];
        // Leaves occupy nodes NSQ-1 .. 2*NSQ-2; node n has children 2n+1, 2n+2.
        for (int k = 0; k < int'(NSQ); k++) begin
            val[NSQ-1+k] = prio[k*PW +: PW];
            idx[NSQ-1+k] = IW'(k);
        end
        for (int n = int'(NSQ) - 2; n >= 0; n--) begin
            if (val[2*n+1] >= val[2*n+2]) begin
                val[n] = val[2*n+1];
                idx[n] = idx[2*n+1];
            end else begin
                val[n] = val[2*n+2];
                idx[n] = idx[2*n+2];
            end
        end
        tree_max = val[0];
        tree_idx = idx[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_prio <= '0;
            max_idx  <= '0;
        end else begin
            max_prio <= tree_max;
            max_idx  <= tree_idx;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: host-side controller for the square array. Loads/clears the
// board over the write bus and runs the MVV-LVA capture loop (find victim,
// find aggressor, disable, repeat), streaming (from,to) moves over
// mv_valid/mv_ready.
//   cmd_*      : host command channel, accepted only in idle (cmd_ready)
//   state_mode, mask_mode, ss1, write_bus, wtm : registered array controls
//   prio_in, king_in : combinational array responses
//   mv_*       : move stream, done pulse and sticky illegal flag
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int unsigned NSQ = 64,
    parameter int unsigned PW  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(NSQ)-1:0]  cmd_sq,
    input  logic [3:0]              cmd_piece,
    input  logic                    cmd_wtm,
    output logic [2:0]              state_mode,
    output logic [1:0]              mask_mode,
    output logic                    wtm,
    output logic [3:0]              write_bus,
    output logic [NSQ-1:0]          ss1,
    input  logic [NSQ*PW-1:0]       prio_in,
    input  logic [NSQ-1:0]          king_in,
    output logic                    mv_valid,
    input  logic                    mv_ready,
    output logic [$clog2(NSQ)-1:0]  mv_from,
    output logic [$clog2(NSQ)-1:0]  mv_to,
    output logic                    mv_done,
    output logic                    mv_illegal
);
    localparam int unsigned SQW = $clog2(NSQ);

    seq_state_e     state_q, state_d;
    logic [SQW-1:0] victim_q, victim_d;
    logic [SQW-1:0] aggr_q, aggr_d;
    logic [SQW-1:0] clr_q, clr_d;
    logic           wtm_q, wtm_d;
    logic           illegal_q, illegal_d;
    logic [2:0]     sm_q, sm_d;
    logic [1:0]     mm_q, mm_d;
    logic [NSQ-1:0] ss1_q, ss1_d;
    logic [3:0]     wb_q, wb_d;

    logic [PW-1:0]  best_max;
    logic [SQW-1:0] best_idx;
    logic           in_gen;
    logic           abort;

    function automatic logic [NSQ-1:0] sq_sel(input logic [SQW-1:0] sq);
        logic [NSQ-1:0] v;
        v     = '0;
        v[sq] = 1'b1;
        return v;
    endfunction

    prio_argmax #(
        .NSQ(NSQ),
        .PW (PW)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .prio    (prio_in),
        .max_prio(best_max),
        .max_idx (best_idx)
    );

    // Abort is honoured in every generation state even though cmd_ready is low.
    assign abort  = cmd_valid && (cmd_op == OP_ABORT);
    assign in_gen = state_q inside {StInit, StFvIssue, StFvCap, StDv, StFaIssue,
                                    StFaCap, StEmit, StDa};

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        aggr_d    = aggr_q;
        clr_d     = clr_q;
        wtm_d     = wtm_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD:  state_d = StLoad;
                        OP_CLEAR: begin
                            state_d = StClear;
                            clr_d   = '0;
                        end
                        OP_GEN: begin
                            state_d   = StInit;
                            wtm_d     = cmd_wtm;
                            illegal_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            StLoad:  state_d = StIdle;
            StClear: begin
                if (clr_q == SQW'(NSQ - 1)) state_d = StIdle;
                else                        clr_d   = clr_q + SQW'(1);
            end
            StInit:    state_d = StFvIssue;
            StFvIssue: state_d = StFvCap;
            StFvCap: begin
                if (|king_in) begin
                    illegal_d = 1'b1;
                    state_d   = StDone;
                end else if (best_max == '0) begin
                    state_d = StDone;
                end else begin
                    victim_d = best_idx;
                    state_d  = StDv;
                end
            end
            StDv:      state_d = StFaIssue;
            StFaIssue: state_d = StFaCap;
            StFaCap: begin
                if (best_max == '0) begin
                    state_d = StFvIssue;
                end else begin
                    aggr_d  = best_idx;
                    state_d = StEmit;
                end
            end
            StEmit: if (mv_ready) state_d = StDa;
            StDa:   state_d = StFaIssue;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (in_gen && abort) state_d = StDone;
    end

    // Array controls are registered: decode them from the state being entered.
    always_comb begin
        sm_d  = SM_FV;
        mm_d  = MM_NONE;
        ss1_d = '0;
        wb_d  = '0;
        case (state_d)
            StLoad: begin
                sm_d  = SM_W;
                ss1_d = sq_sel(cmd_sq);
                wb_d  = cmd_piece;
            end
            StClear: begin
                sm_d  = SM_W;
                ss1_d = sq_sel(clr_d);
                wb_d  = EMPTY;
            end
            StInit: mm_d = MM_EAV_EAA;
            StDv: begin
                mm_d  = MM_DV_EAA;
                ss1_d = sq_sel(victim_d);
            end
            StFaIssue, StFaCap, StEmit: begin
                sm_d  = SM_FA;
                ss1_d = sq_sel(victim_d);
            end
            StDa: begin
                sm_d  = SM_FA;
                mm_d  = MM_DA;
                ss1_d = sq_sel(aggr_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            victim_q  <= '0;
            aggr_q    <= '0;
            clr_q     <= '0;
            wtm_q     <= 1'b0;
            illegal_q <= 1'b0;
            sm_q      <= SM_FV;
            mm_q      <= MM_NONE;
            ss1_q     <= '0;
            wb_q      <= '0;
        end else begin
            state_q   <= state_d;
            victim_q  <= victim_d;
            aggr_q    <= aggr_d;
            clr_q     <= clr_d;
            wtm_q     <= wtm_d;
            illegal_q <= illegal_d;
            sm_q      <= sm_d;
            mm_q      <= mm_d;
            ss1_q     <= ss1_d;
            wb_q      <= wb_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign mv_valid   = (state_q == StEmit);
    assign mv_done    = (state_q == StDone);
    // Victim/aggressor only change in the capture states, so they hold during EMIT.
    assign mv_from    = aggr_q;
    assign mv_to      = victim_q;
    assign mv_illegal = illegal_q;
    assign state_mode = sm_q;
    assign mask_mode  = mm_q;
    assign ss1        = ss1_q;
    assign write_bus  = wb_q;
    assign wtm        = wtm_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer. A behavioural array model answers state_mode /
// mask_mode / ss1 with victim and aggressor priority tables; expected capture
// lists come either from hand-written lists or from an MVV-LVA reference that
// ranks the tables directly.
module tb_move_sequencer;
    import move_sequencer_pkg::*;

    localparam int NSQ = 64;
    localparam int PW  = 3;

    logic              clk, rst_n;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [5:0]        cmd_sq;
    logic [3:0]        cmd_piece;
    logic              cmd_wtm;
    logic [2:0]        state_mode;
    logic [1:0]        mask_mode;
    logic              wtm;
    logic [3:0]        write_bus;
    logic [NSQ-1:0]    ss1;
    logic [NSQ*PW-1:0] prio_in;
    logic [NSQ-1:0]    king_in;
    logic              mv_valid, mv_ready, mv_done, mv_illegal;
    logic [5:0]        mv_from, mv_to;

    move_sequencer #(.NSQ(NSQ), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sq(cmd_sq), .cmd_piece(cmd_piece), .cmd_wtm(cmd_wtm),
        .state_mode(state_mode), .mask_mode(mask_mode), .wtm(wtm), .write_bus(write_bus),
        .ss1(ss1), .prio_in(prio_in), .king_in(king_in), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to), .mv_done(mv_done),
        .mv_illegal(mv_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- array model ----------------
    logic [PW-1:0] pv [NSQ];
    logic [PW-1:0] pa [NSQ][NSQ];
    logic          en_v [NSQ];
    logic          en_a [NSQ];
    logic [3:0]    board [NSQ];

    function automatic int oh_idx(input logic [NSQ-1:0] v);
        for (int i = 0; i < NSQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSQ; i++) begin
                en_v[i] <= 1'b0;
                en_a[i] <= 1'b0;
            end
        end else begin
            if (state_mode == SM_W && ss1 != '0) board[oh_idx(ss1)] <= write_bus;
            case (mask_mode)
                MM_EAV_EAA: for (int i = 0; i < NSQ; i++) begin
                    en_v[i] <= 1'b1;
                    en_a[i] <= 1'b1;
                end
                MM_DV_EAA: begin
                    for (int i = 0; i < NSQ; i++) en_a[i] <= 1'b1;
                    en_v[oh_idx(ss1)] <= 1'b0;
                end
                MM_DA: en_a[oh_idx(ss1)] <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        int sel;
        prio_in = '0;
        sel = oh_idx(ss1);
        for (int sq = 0; sq < NSQ; sq++) begin
            if (state_mode == SM_FV && en_v[sq]) prio_in[sq*PW +: PW] = pv[sq];
            else if (state_mode == SM_FA && en_a[sq]) prio_in[sq*PW +: PW] = pa[sel][sq];
        end
    end

    // ---------------- reference and helpers ----------------
    typedef struct {int from; int to;} mv_t;
    mv_t exp_q[$];

    task automatic clear_tables();
        for (int i = 0; i < NSQ; i++) begin
            pv[i] = '0;
            for (int j = 0; j < NSQ; j++) pa[i][j] = '0;
        end
    endtask

    // Highest-value victim first, then its aggressors by descending priority;
    // equal priorities go to the lower square.
    task automatic build_ref();
        bit vd[NSQ];
        exp_q.delete();
        for (int i = 0; i < NSQ; i++) vd[i] = 1'b0;
        forever begin
            int v, bp;
            bit ad[NSQ];
            v = -1; bp = 0;
            for (int s = 0; s < NSQ; s++) if (!vd[s] && int'(pv[s]) > bp) begin v = s; bp = pv[s]; end
            if (v < 0) break;
            vd[v] = 1'b1;
            for (int i = 0; i < NSQ; i++) ad[i] = 1'b0;
            forever begin
                int a, ap;
                a = -1; ap = 0;
                for (int s = 0; s < NSQ; s++)
                    if (!ad[s] && int'(pa[v][s]) > ap) begin a = s; ap = pa[v][s]; end
                if (a < 0) break;
                ad[a] = 1'b1;
                exp_q.push_back('{from: a, to: v});
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic issue(input logic [1:0] op, input int sq, input logic [3:0] pc, input bit w);
        cmd_valid = 1'b1; cmd_op = op; cmd_sq = 6'(sq); cmd_piece = pc; cmd_wtm = w;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ss1"}, ss1, 64'd0);
        check({tag, " ctrl"},
              {state_mode, mask_mode, write_bus, wtm, cmd_ready, mv_valid, mv_from, mv_to,
               mv_done, mv_illegal},
              {SM_FV, MM_NONE, 4'h0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0});
    endtask

    task automatic run_gen(input string tag, input bit rnd_ready, input bit w,
                           input logic [NSQ-1:0] kings, input bit exp_ill, output int cyc);
        mv_t got[$];
        bit done, hold;
        logic [5:0] hf, ht;
        king_in = kings;
        mv_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        issue(OP_GEN, 0, 4'h0, w);
        check({tag, " wtm"}, wtm, w);
        done = 0; hold = 0; cyc = 0; hf = 0; ht = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (mv_done) done = 1;
            else if (mv_valid) begin
                if (hold) check({tag, " hold"}, {mv_from, mv_to}, {hf, ht});
                if (mv_ready) got.push_back('{from: int'(mv_from), to: int'(mv_to)});
                hold = !mv_ready; hf = mv_from; ht = mv_to;
            end else hold = 0;
            @(posedge clk); #1;
            if (!done) begin
                mv_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc++;
            end
        end
        mv_ready = 1'b0;
        check({tag, " done seen"}, done, 1'b1);
        check({tag, " illegal"}, mv_illegal, exp_ill);
        check({tag, " move count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s move %0d", tag, i), {got[i].from, got[i].to},
                  {exp_q[i].from, exp_q[i].to});
        king_in = '0;
    endtask

    typedef struct {
        int          sq;
        logic [3:0]  piece;
        logic [63:0] exp_ss1;
    } load_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        load_vec_t lv[5];
        int n, cyc, bad, nvic;
        logic [2:0] sm0;

        lv[0] = '{sq: 0,  piece: 4'h4, exp_ss1: 64'h0000_0000_0000_0001};
        lv[1] = '{sq: 56, piece: 4'hD, exp_ss1: 64'h0100_0000_0000_0000};
        lv[2] = '{sq: 7,  piece: 4'h5, exp_ss1: 64'h0000_0000_0000_0080};
        lv[3] = '{sq: 63, piece: 4'hE, exp_ss1: 64'h8000_0000_0000_0000};
        lv[4] = '{sq: 33, piece: 4'h9, exp_ss1: 64'h0000_0002_0000_0000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_sq = 0; cmd_piece = 0;
        cmd_wtm = 0; king_in = '0; mv_ready = 1'b0;
        clear_tables();
        for (int i = 0; i < NSQ; i++) board[i] = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full clear: 64 write cycles, every square EMPTY afterwards.
        issue(OP_CLEAR, 0, 4'h0, 0);
        n = 0;
        while (!cmd_ready && n < 100) begin n++; @(posedge clk); #1; end
        check("clear cycles", n, 64);
        bad = 0;
        for (int i = 0; i < NSQ; i++) if (board[i] !== EMPTY) bad++;
        check("clear board", bad, 0);

        // Table-driven loads.
        for (int i = 0; i < 5; i++) begin
            issue(OP_LOAD, lv[i].sq, lv[i].piece, 0);
            check($sformatf("load%0d write", i), {state_mode, write_bus, cmd_ready},
                  {SM_W, lv[i].piece, 1'b0});
            check($sformatf("load%0d ss1", i), ss1, lv[i].exp_ss1);
            @(posedge clk); #1;
            check($sformatf("load%0d idle", i), {state_mode, mask_mode, cmd_ready, ss1},
                  {SM_FV, MM_NONE, 1'b1, 64'd0});
            check($sformatf("load%0d board", i), board[lv[i].sq], lv[i].piece);
        end

        // Abort while idle does nothing.
        issue(OP_ABORT, 0, 4'h0, 0);
        check("idle abort", {cmd_ready, mv_done, state_mode}, {1'b1, 1'b0, SM_FV});

        // 1: one capture rook 0 x queen 56.
        clear_tables(); pv[56] = 5; pa[56][0] = 3;
        exp_q.delete(); exp_q.push_back('{from: 0, to: 56});
        run_gen("t1", 0, 1, '0, 0, cyc);

        // 2: empty board, done promptly.
        clear_tables(); exp_q.delete();
        run_gen("t2", 0, 0, '0, 0, cyc);
        check("t2 latency ok", cyc <= 4, 1'b1);

        // 3: two attackers on one victim, higher rank first.
        clear_tables(); pv[56] = 4; pa[56][0] = 5; pa[56][7] = 2;
        exp_q.delete();
        exp_q.push_back('{from: 0, to: 56}); exp_q.push_back('{from: 7, to: 56});
        run_gen("t3", 1, 1, '0, 0, cyc);

        // 3b: victim and aggressor ties resolve to the lower square.
        clear_tables(); pv[48] = 6; pv[40] = 6; pa[40][9] = 2; pa[40][3] = 2; pa[48][1] = 1;
        exp_q.delete();
        exp_q.push_back('{from: 3, to: 40}); exp_q.push_back('{from: 9, to: 40});
        exp_q.push_back('{from: 1, to: 48});
        run_gen("t3b", 1, 0, '0, 0, cyc);

        // 4: king capture available -> illegal, no moves.
        clear_tables(); pv[60] = 7; pa[60][4] = 3;
        exp_q.delete();
        run_gen("t4", 0, 1, 64'd1 << 60, 1, cyc);

        // 5: consumer stalls 10 cycles during EMIT.
        clear_tables(); pv[20] = 3; pa[20][5] = 1;
        mv_ready = 1'b0;
        issue(OP_GEN, 0, 4'h0, 1);
        check("t5 illegal cleared", mv_illegal, 1'b0);
        n = 0;
        while (!mv_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("t5 valid seen", mv_valid, 1'b1);
        sm0 = state_mode;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t5 stall %0d", i), {mv_valid, mv_from, mv_to, state_mode},
                  {1'b1, 6'd5, 6'd20, sm0});
        end
        check("t5 state_mode", sm0, SM_FA);
        @(posedge clk); #1; mv_ready = 1'b1;
        @(negedge clk);
        check("t5 transfer", {mv_valid, mv_from, mv_to}, {1'b1, 6'd5, 6'd20});
        @(posedge clk); #1; mv_ready = 1'b0;
        check("t5 valid drops", mv_valid, 1'b0);
        n = 0; bad = 0;
        while (!mv_done && n < 20) begin
            if (mv_valid) bad++;
            @(posedge clk); #1; n++;
        end
        check("t5 done", mv_done, 1'b1);
        check("t5 no extra", bad, 0);
        @(posedge clk); #1;

        // 6: abort a pending move, then reset in the middle of a clear.
        clear_tables(); pv[20] = 3; pa[20][5] = 1; pa[20][6] = 1;
        mv_ready = 1'b0;
        issue(OP_GEN, 0, 4'h0, 0);
        n = 0;
        while (!mv_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("t6 valid seen", mv_valid, 1'b1);
        issue(OP_ABORT, 0, 4'h0, 0);
        @(negedge clk);
        check("t6 abort done", {mv_done, mv_valid}, {1'b1, 1'b0});
        @(posedge clk); #1;
        check("t6 back idle", {mv_done, cmd_ready, mv_valid}, {1'b0, 1'b1, 1'b0});

        issue(OP_CLEAR, 0, 4'h0, 0);
        repeat (9) begin @(posedge clk); #1; end
        check("t6 clear step", {state_mode, cmd_ready, write_bus}, {SM_W, 1'b0, EMPTY});
        check("t6 clear ss1", ss1, 64'd1 << 9);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t6 async reset");
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("t6 after reset");
        @(posedge clk); #1;

        // Random boards against the reference ranking.
        for (int t = 0; t < 8; t++) begin
            clear_tables();
            nvic = $urandom_range(0, 4);
            for (int k = 0; k < nvic; k++) begin
                int v;
                v = $urandom_range(0, NSQ - 1);
                pv[v] = 3'($urandom_range(1, 7));
                for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                    pa[v][$urandom_range(0, NSQ - 1)] = 3'($urandom_range(1, 7));
            end
            build_ref();
            run_gen($sformatf("rnd%0d", t), 1, 1'($urandom_range(0, 1)), '0, 0, cyc);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
